multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
// - Multicycle control FSM for the 3-bit-opcode core. Sequences fetch/decode/execute/memory/writeback.
// - Turns the combinational decoder's level controls into single-cycle datapath strobes.
// - Runs the instruction- and data-memory request/ready handshakes.
// - Sits between the decoder, the PC/IR registers, the register file and the memory ports.
// PARAMETERS
// - TIMEOUT_CYCLES  16  max wait cycles on a memory handshake before FAULT (used only with MEM_TIMEOUT_EN)
// - TMR_W           5   width of the wait counter; must satisfy 2**TMR_W > TIMEOUT_CYCLES
// PORTS
// - CLK           in   1  single clock, rising edge
// - reset         in   1  asynchronous, active-low reset
// - ctl_regwrite  in   1  decoder RegWrite level
// - ctl_memread   in   1  decoder MemRead level
// - ctl_memwrite  in   1  decoder MemWrite level
// - ctl_branch    in   1  decoder Branch level
// - ctl_jumpout   in   1  decoder JumpOut level
// - branch_taken  in   1  ALU compare result; valid in EXEC
// - imem_ready    in   1  instruction memory data valid
// - dmem_ready    in   1  data memory access complete
// - halt_req      in   1  stop at the next instruction boundary
// - imem_req      out  1  instruction fetch request
// - ir_load       out  1  IR capture strobe
// - pc_write      out  1  PC update strobe
// - pc_src        out  2  0 = PC+1, 1 = branch/jump target, 2 = register (jump out)
// - dmem_req      out  1  data memory request
// - dmem_we       out  1  data memory write enable; valid with dmem_req
// - rf_we         out  1  register file write strobe
// - busy          out  1  instruction in flight
// - state         out  3  current FSM state, for debug
// - fault         out  1  memory timeout fault
// BEHAVIOUR
// - States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
// - Reset low: immediately enter IDLE. All outputs 0, latched controls 0, wait counter 0.
//   - Reset mid-instruction drops any request at once. No strobes are emitted.
// - IDLE: go to HALT if halt_req, otherwise FETCH, on the next cycle.
// - FETCH: hold imem_req=1 until imem_ready.
//   - In the imem_ready cycle: ir_load=1, next state DECODE.
// - DECODE: one cycle. Register the five ctl_* inputs at the end of DECODE.
//   - All later decisions use the registered copies only.
// - EXEC: one cycle. Register taken = jumpout | (branch & (regwrite | branch_taken)).
//   - pc_src register: 2 if jumpout, 1 if taken, else 0.
//   - If memread or memwrite: go to MEM.
//   - Else if regwrite: go to WB.
//   - Else: pc_write=1 in this cycle with the new pc_src, then go to the boundary.
// - MEM: hold dmem_req=1 and dmem_we=memwrite until dmem_ready.
//   - On ready with memread: go to WB.
//   - On ready without memread: pc_write=1, then go to the boundary.
// - WB: one cycle. rf_we=1 and pc_write=1 in the same cycle, then go to the boundary.
// - Every instruction emits exactly one pc_write pulse. rf_we is at most one pulse.
// - Boundary: go to HALT if halt_req, otherwise FETCH.
//   - halt_req is sampled only at the boundary and in IDLE.
// - HALT: busy=0. Leave for FETCH on the first cycle with halt_req=0.
// - busy=1 in FETCH, DECODE, EXEC, MEM and WB; 0 otherwise.
// - Strobes are decoded from the state register plus ready inputs. ir_load and the ready-cycle pc_write are combinational on ready.
// - Ready asserted on the same cycle as the request is legal (zero wait states). Ready outside a request state is ignored.
// - Latency: ALU-only 5 cycles; LW 6; SW 5; branch 4; each imem/dmem wait cycle adds 1.
// CONFIGURATION
// - MEM_TIMEOUT_EN defined:
//   - Wait counter clears on entry to FETCH or MEM and increments each cycle without ready.
//   - Reaching TIMEOUT_CYCLES enters FAULT: fault=1, all requests and strobes 0.
//   - FAULT is left only by reset.
// - MEM_TIMEOUT_EN undefined: waits are unbounded; no counter; fault tied 0; FAULT unreachable.
// STRUCTURE
// - miscv_pkg: state encodings, PC_SRC_* constants, OPC_* opcode constants.
// - Sub-module mem_wait_timer: clear / enable / expired. Instantiated only under MEM_TIMEOUT_EN.
// TESTING
// - R-type, zero-wait memory: cycles IDLE,F,D,E,WB; rf_we and pc_write together in WB; pc_src=0.
// - LW, imem_ready delayed 2 and dmem_ready delayed 3: imem_req high 3 cycles, dmem_req high 4 cycles, dmem_we=0, rf_we once.
// - SW: dmem_we=1 with dmem_req; pc_write in the dmem_ready cycle; rf_we never 1.
// - Branch opcode 4 with branch_taken=1 then 0: pc_src=1 then 0; one pc_write in EXEC; jump out gives pc_src=2.
// - halt_req raised during EXEC of an ALU op: WB completes, HALT entered, busy=0; drop halt_req -> FETCH next cycle.
// - Reset pulled low during MEM: dmem_req=0 the same cycle, state=0. With MEM_TIMEOUT_EN and no ready for 16 cycles: fault=1, state=7.

Source files
------------

// File: rtl/miscv_pkg.sv
// Shared encodings for the 3-bit-opcode multicycle core: FSM states,
// PC source selects, opcodes and the latched decoder control bundle.
package miscv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6,
      ST_FAULT  = 3'd7
   } state_e;

   localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
   localparam logic [1:0] PC_SRC_TARGET = 2'd1;
   localparam logic [1:0] PC_SRC_REG    = 2'd2;

   localparam logic [2:0] OPC_ALU  = 3'd0;
   localparam logic [2:0] OPC_ADDI = 3'd1;
   localparam logic [2:0] OPC_LW   = 3'd2;
   localparam logic [2:0] OPC_SW   = 3'd3;
   localparam logic [2:0] OPC_BEQ  = 3'd4;
   localparam logic [2:0] OPC_JAL  = 3'd5;
   localparam logic [2:0] OPC_JR   = 3'd6;
   localparam logic [2:0] OPC_NOP  = 3'd7;

   typedef struct packed {
      logic regwrite;
      logic memread;
      logic memwrite;
      logic branch;
      logic jumpout;
   } ctl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for memory handshakes; expired is raised on the last
// allowed wait cycle so the sequencer can leave for FAULT on the next edge.
module mem_wait_timer #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int TMR_W          = 5
) (
   input  logic CLK,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [TMR_W-1:0] count_q;
   logic [TMR_W-1:0] count_d;

   assign expired = (count_q == TMR_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !expired) begin
         count_d = count_q + TMR_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback with
// single-cycle datapath strobes. Optional memory timeout under MEM_TIMEOUT_EN.
module multicycle_sequencer
   import miscv_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int TMR_W          = 5
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       ctl_regwrite,
   input  logic       ctl_memread,
   input  logic       ctl_memwrite,
   input  logic       ctl_branch,
   input  logic       ctl_jumpout,
   input  logic       branch_taken,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   input  logic       halt_req,
   output logic       imem_req,
   output logic       ir_load,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       dmem_req,
   output logic       dmem_we,
   output logic       rf_we,
   output logic       busy,
   output logic [2:0] state,
   output logic       fault
);

   state_e     state_q, state_d;
   ctl_t       ctl_q, ctl_d;
   logic [1:0] pc_src_q, pc_src_d;
   state_e     boundary_st;
   logic       taken;
   logic       tmr_expired;

   assign taken       = ctl_q.jumpout | (ctl_q.branch & (ctl_q.regwrite | branch_taken));
   assign boundary_st = halt_req ? ST_HALT : ST_FETCH;

   always_comb begin
      state_d  = state_q;
      ctl_d    = ctl_q;
      pc_src_d = pc_src_q;
      imem_req = 1'b0;
      ir_load  = 1'b0;
      pc_write = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      case (state_q)
         ST_IDLE: state_d = boundary_st;
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_load = 1'b1;
               state_d = ST_DECODE;
            end else if (tmr_expired) begin
               state_d = ST_FAULT;
            end
         end
         ST_DECODE: begin
            ctl_d   = '{regwrite: ctl_regwrite, memread: ctl_memread, memwrite: ctl_memwrite,
                        branch: ctl_branch, jumpout: ctl_jumpout};
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            pc_src_d = ctl_q.jumpout ? PC_SRC_REG : (taken ? PC_SRC_TARGET : PC_SRC_SEQ);
            if (ctl_q.memread || ctl_q.memwrite) begin
               state_d = ST_MEM;
            end else if (ctl_q.regwrite) begin
               state_d = ST_WB;
            end else begin
               pc_write = 1'b1;
               state_d  = boundary_st;
            end
         end
         ST_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = ctl_q.memwrite;
            if (dmem_ready) begin
               if (ctl_q.memread) begin
                  state_d = ST_WB;
               end else begin
                  pc_write = 1'b1;
                  state_d  = boundary_st;
               end
            end else if (tmr_expired) begin
               state_d = ST_FAULT;
            end
         end
         ST_WB: begin
            rf_we    = 1'b1;
            pc_write = 1'b1;
            state_d  = boundary_st;
         end
         ST_HALT: if (!halt_req) state_d = ST_FETCH;
         default: state_d = ST_FAULT;
      endcase
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         ctl_q    <= '0;
         pc_src_q <= PC_SRC_SEQ;
      end else begin
         state_q  <= state_d;
         ctl_q    <= ctl_d;
         pc_src_q <= pc_src_d;
      end
   end

   // The new select is visible during EXEC so an EXEC-cycle pc_write uses it.
   assign pc_src = (state_q == ST_EXEC) ? pc_src_d : pc_src_q;
   assign busy   = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                   (state_q == ST_MEM) || (state_q == ST_WB);
   assign state  = state_q;

`ifdef MEM_TIMEOUT_EN
   mem_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TMR_W          (TMR_W)
   ) u_mem_wait_timer (
      .CLK     (CLK),
      .reset   (reset),
      .clear   (state_d != state_q),
      .enable  ((state_q == ST_FETCH && !imem_ready) || (state_q == ST_MEM && !dmem_ready)),
      .expired (tmr_expired)
   );
   assign fault = (state_q == ST_FAULT);
`else
   logic unused_cfg;
   assign unused_cfg  = TIMEOUT_CYCLES[0] ^ TMR_W[0];
   assign tmr_expired = 1'b0;
   assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench: an instruction-level model expands each instruction into an
// expected per-cycle trace, with noise on every input the design must ignore.
module tb_multicycle_sequencer;
   import miscv_pkg::*;

   logic       CLK = 1'b0;
   logic       reset = 1'b0;
   logic       ctl_regwrite = 0, ctl_memread = 0, ctl_memwrite = 0, ctl_branch = 0, ctl_jumpout = 0;
   logic       branch_taken = 0, imem_ready = 0, dmem_ready = 0, halt_req = 0;
   logic       imem_req, ir_load, pc_write, dmem_req, dmem_we, rf_we, busy, fault;
   logic [1:0] pc_src;
   logic [2:0] state;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [4:0] ctl;     // {regwrite, memread, memwrite, branch, jumpout}
      logic       bt, ir, dr, hr;
      logic [2:0] st;
      logic       busy, imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_write, fault;
      logic [1:0] pc_src;
      logic       chk_pc;
   } cyc_t;

   cyc_t q[$];

   multicycle_sequencer dut (
      .CLK(CLK), .reset(reset),
      .ctl_regwrite(ctl_regwrite), .ctl_memread(ctl_memread), .ctl_memwrite(ctl_memwrite),
      .ctl_branch(ctl_branch), .ctl_jumpout(ctl_jumpout), .branch_taken(branch_taken),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .halt_req(halt_req),
      .imem_req(imem_req), .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we), .busy(busy),
      .state(state), .fault(fault)
   );

   always #5 CLK = ~CLK;

   function automatic logic [4:0] dec(input logic [2:0] opc);
      case (opc)
         OPC_ALU, OPC_ADDI: dec = 5'b10000;
         OPC_LW:            dec = 5'b11000;
         OPC_SW:            dec = 5'b00100;
         OPC_BEQ:           dec = 5'b00010;
         OPC_JAL:           dec = 5'b10010;
         OPC_JR:            dec = 5'b00001;
         default:           dec = 5'b00000;
      endcase
   endfunction

   function automatic cyc_t mk(input logic [2:0] st);
      cyc_t c;
      c.ctl = 5'($urandom); c.bt = 1'($urandom); c.ir = 1'($urandom);
      c.dr = 1'($urandom);  c.hr = 1'($urandom);
      c.st = st; c.busy = (st >= 3'd1 && st <= 3'd5);
      c.imem_req = 0; c.ir_load = 0; c.dmem_req = 0; c.dmem_we = 0;
      c.rf_we = 0; c.pc_write = 0; c.fault = 0; c.pc_src = 2'd0; c.chk_pc = 0;
      return c;
   endfunction

   function automatic logic [10:0] exp_vec(input cyc_t c);
      return {c.st, c.busy, c.imem_req, c.ir_load, c.dmem_req, c.dmem_we, c.rf_we, c.pc_write, c.fault};
   endfunction

   function automatic logic [10:0] obs_vec();
      return {state, busy, imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_write, fault};
   endfunction

   task automatic drive(input cyc_t c);
      {ctl_regwrite, ctl_memread, ctl_memwrite, ctl_branch, ctl_jumpout} = c.ctl;
      branch_taken = c.bt; imem_ready = c.ir; dmem_ready = c.dr; halt_req = c.hr;
   endtask

   // Instruction-level reference: taken/pc_src and the phase list follow directly
   // from the decoded controls, wait counts and halt request.
   task automatic add_instr(input logic [4:0] ctl, input logic bt, input int iw, input int dw,
                            input logic halt, input int hold);
      cyc_t c;
      logic rw, mr, mw, br, jo, taken, mem;
      logic [1:0] src;
      {rw, mr, mw, br, jo} = ctl;
      taken = jo | (br & (rw | bt));
      src   = jo ? 2'd2 : (taken ? 2'd1 : 2'd0);
      mem   = mr | mw;
      $display("txn ctl=%b bt=%0d iwait=%0d dwait=%0d halt=%0d pc_src=%0d", ctl, bt, iw, dw, halt, src);
      for (int i = 0; i <= iw; i++) begin
         c = mk(3'd1); c.ir = (i == iw); c.imem_req = 1; c.ir_load = (i == iw); q.push_back(c);
      end
      c = mk(3'd2); c.ctl = ctl; q.push_back(c);
      c = mk(3'd3); c.bt = bt; c.hr = halt; c.chk_pc = 1; c.pc_src = src;
      if (!mem && !rw) c.pc_write = 1;
      q.push_back(c);
      if (mem) begin
         for (int i = 0; i <= dw; i++) begin
            c = mk(3'd4); c.dr = (i == dw); c.hr = halt; c.dmem_req = 1; c.dmem_we = mw;
            if (i == dw && !mr) begin c.pc_write = 1; c.chk_pc = 1; c.pc_src = src; end
            q.push_back(c);
         end
      end
      if (mr || (!mem && rw)) begin
         c = mk(3'd5); c.hr = halt; c.rf_we = 1; c.pc_write = 1; c.chk_pc = 1; c.pc_src = src;
         q.push_back(c);
      end
      if (halt) begin
         for (int i = 0; i < hold; i++) begin c = mk(3'd6); c.hr = 1; q.push_back(c); end
         c = mk(3'd6); c.hr = 0; q.push_back(c);
      end
   endtask

   task automatic test_reset();
      cyc_t c;
      repeat (2) @(posedge CLK);
      #1;
      @(negedge CLK);
      n_checks++;
      if ({obs_vec(), pc_src} !== 13'd0) begin
         n_fail++; $display("FAIL reset_state got=%b want=0", {obs_vec(), pc_src});
      end
      @(posedge CLK); #1;
      reset = 1'b1;
      c = mk(3'd0); c.hr = 0; q.push_back(c);
      while (q.size() > 0) begin
         c = q.pop_front(); drive(c); @(negedge CLK); n_checks++;
         if (obs_vec() !== exp_vec(c) || (c.chk_pc && pc_src !== c.pc_src)) begin
            n_fail++; $display("FAIL idle got=%b/%0d want=%b/%0d", obs_vec(), pc_src, exp_vec(c), c.pc_src);
         end
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_rtype();
      cyc_t c;
      add_instr(dec(OPC_ALU), 1'b0, 0, 0, 1'b0, 0);
      while (q.size() > 0) begin
         c = q.pop_front(); drive(c); @(negedge CLK); n_checks++;
         if (obs_vec() !== exp_vec(c) || (c.chk_pc && pc_src !== c.pc_src)) begin
            n_fail++; $display("FAIL rtype got=%b/%0d want=%b/%0d", obs_vec(), pc_src, exp_vec(c), c.pc_src);
         end
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_lw_waits();
      cyc_t c;
      int n_imem = 0, n_dmem = 0, n_rf = 0, n_we = 0;
      add_instr(dec(OPC_LW), 1'($urandom), 2, 3, 1'b0, 0);
      while (q.size() > 0) begin
         c = q.pop_front(); drive(c); @(negedge CLK); n_checks++;
         if (obs_vec() !== exp_vec(c) || (c.chk_pc && pc_src !== c.pc_src)) begin
            n_fail++; $display("FAIL lw got=%b/%0d want=%b/%0d", obs_vec(), pc_src, exp_vec(c), c.pc_src);
         end
         n_imem += int'(imem_req); n_dmem += int'(dmem_req); n_rf += int'(rf_we); n_we += int'(dmem_we);
         @(posedge CLK); #1;
      end
      n_checks++;
      if (n_imem != 3 || n_dmem != 4 || n_rf != 1 || n_we != 0) begin
         n_fail++;
         $display("FAIL lw_counts got imem=%0d dmem=%0d rf=%0d we=%0d want 3 4 1 0", n_imem, n_dmem, n_rf, n_we);
      end
   endtask

   task automatic test_sw();
      cyc_t c;
      add_instr(dec(OPC_SW), 1'($urandom), 1, 2, 1'b0, 0);
      add_instr(dec(OPC_SW), 1'($urandom), 0, 0, 1'b0, 0);
      while (q.size() > 0) begin
         c = q.pop_front(); drive(c); @(negedge CLK); n_checks++;
         if (obs_vec() !== exp_vec(c) || (c.chk_pc && pc_src !== c.pc_src)) begin
            n_fail++; $display("FAIL sw got=%b/%0d want=%b/%0d", obs_vec(), pc_src, exp_vec(c), c.pc_src);
         end
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_branch_jump();
      cyc_t c;
      add_instr(dec(OPC_BEQ), 1'b1, 0, 0, 1'b0, 0);
      add_instr(dec(OPC_BEQ), 1'b0, 1, 0, 1'b0, 0);
      add_instr(dec(OPC_JR),  1'b0, 0, 0, 1'b0, 0);
      add_instr(dec(OPC_JAL), 1'b0, 0, 0, 1'b0, 0);
      add_instr(dec(OPC_NOP), 1'b1, 0, 0, 1'b0, 0);
      while (q.size() > 0) begin
         c = q.pop_front(); drive(c); @(negedge CLK); n_checks++;
         if (obs_vec() !== exp_vec(c) || (c.chk_pc && pc_src !== c.pc_src)) begin
            n_fail++; $display("FAIL branch got=%b/%0d want=%b/%0d", obs_vec(), pc_src, exp_vec(c), c.pc_src);
         end
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_halt();
      cyc_t c;
      add_instr(dec(OPC_ALU), 1'b0, 0, 0, 1'b1, 3);
      add_instr(dec(OPC_LW),  1'b0, 1, 1, 1'b1, 0);
      while (q.size() > 0) begin
         c = q.pop_front(); drive(c); @(negedge CLK); n_checks++;
         if (obs_vec() !== exp_vec(c) || (c.chk_pc && pc_src !== c.pc_src)) begin
            n_fail++; $display("FAIL halt got=%b/%0d want=%b/%0d", obs_vec(), pc_src, exp_vec(c), c.pc_src);
         end
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_random_stream();
      cyc_t c;
      logic [4:0] ctl;
      for (int n = 0; n < 40; n++) begin
         ctl = ($urandom_range(0, 3) == 0) ? 5'($urandom) : dec(3'($urandom));
         add_instr(ctl, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)));
      end
      while (q.size() > 0) begin
         c = q.pop_front(); drive(c); @(negedge CLK); n_checks++;
         if (obs_vec() !== exp_vec(c) || (c.chk_pc && pc_src !== c.pc_src)) begin
            n_fail++; $display("FAIL random got=%b/%0d want=%b/%0d", obs_vec(), pc_src, exp_vec(c), c.pc_src);
         end
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_reset_mid_mem();
      cyc_t c;
      int n_mem = 0;
      bit done = 0;
      add_instr(dec(OPC_SW), 1'b0, 0, 8, 1'b0, 0);
      while (q.size() > 0 && !done) begin
         c = q.pop_front(); drive(c); @(negedge CLK); n_checks++;
         if (obs_vec() !== exp_vec(c) || (c.chk_pc && pc_src !== c.pc_src)) begin
            n_fail++; $display("FAIL pre_reset got=%b/%0d want=%b/%0d", obs_vec(), pc_src, exp_vec(c), c.pc_src);
         end
         if (c.st == 3'd4) n_mem++;
         if (n_mem == 2) begin
            reset = 1'b0; #1; n_checks++;
            if ({obs_vec(), pc_src} !== 13'd0) begin
               n_fail++; $display("FAIL reset_mid_mem got=%b want=0", {obs_vec(), pc_src});
            end
            done = 1;
         end
         @(posedge CLK); #1;
      end
      q.delete();
      reset = 1'b1;
      c = mk(3'd0); c.hr = 0; q.push_back(c);
      add_instr(dec(OPC_ALU), 1'b0, 0, 0, 1'b0, 0);
      while (q.size() > 0) begin
         c = q.pop_front(); drive(c); @(negedge CLK); n_checks++;
         if (obs_vec() !== exp_vec(c) || (c.chk_pc && pc_src !== c.pc_src)) begin
            n_fail++; $display("FAIL post_reset got=%b/%0d want=%b/%0d", obs_vec(), pc_src, exp_vec(c), c.pc_src);
         end
         @(posedge CLK); #1;
      end
   endtask

`ifdef MEM_TIMEOUT_EN
   task automatic test_timeout();
      cyc_t c;
      $display("txn fetch with no imem_ready for 16 cycles");
      for (int i = 0; i < 16; i++) begin
         c = mk(3'd1); c.ir = 0; c.imem_req = 1; q.push_back(c);
      end
      for (int i = 0; i < 4; i++) begin
         c = mk(3'd7); c.fault = 1; q.push_back(c);
      end
      while (q.size() > 0) begin
         c = q.pop_front(); drive(c); @(negedge CLK); n_checks++;
         if (obs_vec() !== exp_vec(c)) begin
            n_fail++; $display("FAIL timeout got=%b want=%b", obs_vec(), exp_vec(c));
         end
         @(posedge CLK); #1;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_rtype();
      test_lw_waits();
      test_sw();
      test_branch_jump();
      test_halt();
      test_random_stream();
      test_reset_mid_mem();
`ifdef MEM_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
